tmr_recovery_ctrl: RTL and testbench
====================================

# tmr_recovery_ctrl

Recovery controller for the triple-modular-redundant RISC-V core. Watches the voter's 3-bit agreement vector, separates transient glitches from persistent divergence, and drives the three replicas back into lock-step. It either copies the register file from a healthy replica into the faulty one, or rolls all three back to the last fully-agreed PC. It sits beside the voter, feeding stall, register-copy and PC-load controls to cores A, B and C.

## Interface
- CONFIRM_CYCLES, 2: consecutive cycles a non-unanimous pattern must hold before recovery starts (≥1)
- NUM_REGS, 32: architectural registers copied during resync
- ROLLBACK_LIMIT, 3: consecutive rollbacks before fatal lock
- CNT_W, 8: width of saturating fault counters
- clk  in  1  clock, rising edge
- rst_in  in  1  asynchronous, active-low reset
- voter_state  in  3  agreement flags {A==B, B==C, A==C}; 3'b111 = unanimous
- pc_voted  in  32  voted PC
- stall  out  1  freeze all three replicas
- resync_en  out  1  register copy active this cycle
- resync_src  out  2  source replica (0=A, 1=B, 2=C)
- resync_dst  out  2  destination replica
- resync_idx  out  5  register index being copied
- pc_load  out  3  one-hot per replica {A,B,C}; load pc_load_val this cycle
- pc_load_val  out  32  PC to load
- fault_count_a/b/c  out  CNT_W each  persistent faults attributed per replica, saturating
- transient_count  out  CNT_W  mismatches that cleared before confirmation, saturating
- fatal  out  1  sticky uncorrectable-fault flag
- ctrl_state  out  3  current FSM state encoding (debug)

## Operation
- Pattern decode: 100 → C faulty (src A); 001 → B faulty (src A); 010 → A faulty (src B); 000, 011, 101, 110 → no single culprit (rollback class).
- States: RUN, CONFIRM, RESYNC, PCLOAD, ROLLBACK, FATAL.
- RUN: stall=0. If voter_state==111, ckpt_pc ← pc_voted and consec_rb ← 0. Else latch pattern, conf_cnt ← 1, go CONFIRM (RESYNC/ROLLBACK directly if CONFIRM_CYCLES==1).
- CONFIRM: stall=0. 111 → transient_count++, RUN. Same pattern → conf_cnt++; on reaching CONFIRM_CYCLES, single-fault class → RESYNC, else → ROLLBACK. Different non-111 pattern → relatch, conf_cnt ← 1.
- RESYNC entry: resync_pc ← pc_voted, faulty replica's fault_count++. Each cycle: stall=1, resync_en=1, resync_idx = 0..NUM_REGS-1. Core ignores index 0. After idx NUM_REGS-1 → PCLOAD.
- PCLOAD: stall=1, pc_load = faulty one-hot, pc_load_val = resync_pc, one cycle → RUN.
- ROLLBACK: stall=1, pc_load=111, pc_load_val=ckpt_pc, consec_rb++, one cycle. Next state is FATAL if consec_rb reaches ROLLBACK_LIMIT, else RUN.
- FATAL: stall=1, fatal=1; left only by reset.
- voter_state is ignored in RESYNC, PCLOAD, ROLLBACK and FATAL.
- Counters saturate at all-ones.

## Timing
- Reset values: state RUN. stall, resync_en, pc_load and fatal are 0. resync_src, resync_dst, resync_idx, pc_load_val, ckpt_pc and all counters are 0. ctrl_state=RUN.
- All outputs registered. Decisions take effect the cycle after the triggering voter_state sample.
- Minimum detection-to-stall latency is CONFIRM_CYCLES cycles. A resync holds stall for NUM_REGS+1 cycles. A rollback holds stall for 1 cycle.
- ckpt_pc is updated only in RUN with unanimous vote. A mismatch on the first cycle after reset rolls back to 0.
- Asynchronous reset mid-resync or in FATAL returns immediately to RUN with all outputs at reset values.

## Structure
- Shared package tmr_pkg holds the state enum, replica IDs (A=0, B=1, C=2) and the pattern constants (UNANIMOUS=3'b111, C_BAD=3'b100, B_BAD=3'b001, A_BAD=3'b010).
- One sub-module, tmr_fault_decode: combinational pattern → {single_fault, faulty_id, src_id}.
- The FSM, counters and checkpoint registers live in the top.

## Test plan
- Unanimous 111 with pc_voted stepping 0x0,0x4,0x8, then a single 100 cycle, then 111 → no stall, transient_count=1, ckpt_pc tracks the last unanimous PC.
- 100 held for 2 cycles at pc_voted=0x40 → RESYNC with src=0 and dst=2, idx 0..31 over 32 cycles. Then pc_load=001 with pc_load_val=0x40. fault_count_c=1, then RUN.
- 010 persistent → src=1, dst=0, fault_count_a=1. 001 persistent → src=0, dst=1.
- Last unanimous pc_voted=0x100, then 000 held 2 cycles → ROLLBACK with pc_load=111 and pc_load_val=0x100. Three such events with no intervening unanimous RUN cycle → fatal=1, stall=1 persisting.
- Pattern 100 then 001 on consecutive cycles → confirm restarts. RESYNC targets B only after 001 has been held 2 cycles.
- rst_in pulsed low at resync_idx=10 → outputs return to reset values asynchronously. After release the FSM is in RUN and counters are 0.

Source files
------------

// File: rtl/tmr_pkg.sv
// rtl/tmr_pkg.sv - shared states, replica ids and voter patterns for the TMR recovery controller
package tmr_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_CONFIRM  = 3'd1,
        ST_RESYNC   = 3'd2,
        ST_PCLOAD   = 3'd3,
        ST_ROLLBACK = 3'd4,
        ST_FATAL    = 3'd5
    } ctrl_state_e;

    localparam logic [1:0] ID_A = 2'd0;
    localparam logic [1:0] ID_B = 2'd1;
    localparam logic [1:0] ID_C = 2'd2;

    localparam logic [2:0] UNANIMOUS = 3'b111;
    localparam logic [2:0] C_BAD     = 3'b100;
    localparam logic [2:0] B_BAD     = 3'b001;
    localparam logic [2:0] A_BAD     = 3'b010;

    // pc_load bit order is {A,B,C}
    function automatic logic [2:0] replica_onehot(input logic [1:0] id);
        logic [2:0] oh;
        case (id)
            ID_A:    oh = 3'b100;
            ID_B:    oh = 3'b010;
            ID_C:    oh = 3'b001;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/tmr_fault_decode.sv
// rtl/tmr_fault_decode.sv - maps a voter agreement pattern to a single culprit and a healthy source
module tmr_fault_decode
    import tmr_pkg::*;
(
    input  logic [2:0] pattern,
    output logic       single_fault,
    output logic [1:0] faulty_id,
    output logic [1:0] src_id
);

    always_comb begin
        single_fault = 1'b0;
        faulty_id    = ID_A;
        src_id       = ID_A;
        case (pattern)
            C_BAD: begin
                single_fault = 1'b1;
                faulty_id    = ID_C;
                src_id       = ID_A;
            end
            B_BAD: begin
                single_fault = 1'b1;
                faulty_id    = ID_B;
                src_id       = ID_A;
            end
            A_BAD: begin
                single_fault = 1'b1;
                faulty_id    = ID_A;
                src_id       = ID_B;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/tmr_recovery_ctrl.sv
// rtl/tmr_recovery_ctrl.sv - confirms voter divergence and drives register resync or checkpoint rollback
module tmr_recovery_ctrl
    import tmr_pkg::*;
#(
    parameter int CONFIRM_CYCLES = 2,
    parameter int NUM_REGS       = 32,
    parameter int ROLLBACK_LIMIT = 3,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic [2:0]       voter_state,
    input  logic [31:0]      pc_voted,
    output logic             stall,
    output logic             resync_en,
    output logic [1:0]       resync_src,
    output logic [1:0]       resync_dst,
    output logic [4:0]       resync_idx,
    output logic [2:0]       pc_load,
    output logic [31:0]      pc_load_val,
    output logic [CNT_W-1:0] fault_count_a,
    output logic [CNT_W-1:0] fault_count_b,
    output logic [CNT_W-1:0] fault_count_c,
    output logic [CNT_W-1:0] transient_count,
    output logic             fatal,
    output logic [2:0]       ctrl_state
);

    localparam logic [15:0]      CONF_MAX = 16'(CONFIRM_CYCLES);
    localparam logic [4:0]       IDX_LAST = 5'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0] RB_MAX   = CNT_W'(ROLLBACK_LIMIT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    ctrl_state_e      state, state_n;
    logic [2:0]       pattern_q, pattern_n;
    logic [15:0]      conf_cnt, conf_n;
    logic [31:0]      ckpt_pc;
    logic [31:0]      resync_pc;
    logic [CNT_W-1:0] consec_rb;
    logic [CNT_W-1:0] rb_inc;
    logic             single_fault;
    logic [1:0]       faulty_id;
    logic [1:0]       src_id;
    logic             enter_resync;
    logic             unanimous;

    tmr_fault_decode u_decode (
        .pattern      (voter_state),
        .single_fault (single_fault),
        .faulty_id    (faulty_id),
        .src_id       (src_id)
    );

    assign unanimous    = (voter_state == UNANIMOUS);
    assign rb_inc       = sat_inc(consec_rb);
    assign enter_resync = (state_n == ST_RESYNC) && (state != ST_RESYNC);
    assign ctrl_state   = state;

    always_comb begin
        state_n   = state;
        pattern_n = pattern_q;
        conf_n    = conf_cnt;
        case (state)
            ST_RUN: begin
                if (!unanimous) begin
                    pattern_n = voter_state;
                    conf_n    = 16'd1;
                    if (CONF_MAX <= 16'd1) begin
                        state_n = single_fault ? ST_RESYNC : ST_ROLLBACK;
                    end else begin
                        state_n = ST_CONFIRM;
                    end
                end
            end
            ST_CONFIRM: begin
                if (unanimous) begin
                    state_n = ST_RUN;
                end else if (voter_state == pattern_q) begin
                    conf_n = conf_cnt + 16'd1;
                    if (conf_n >= CONF_MAX) begin
                        state_n = single_fault ? ST_RESYNC : ST_ROLLBACK;
                    end
                end else begin
                    pattern_n = voter_state;
                    conf_n    = 16'd1;
                end
            end
            ST_RESYNC: begin
                if (resync_idx == IDX_LAST) begin
                    state_n = ST_PCLOAD;
                end
            end
            ST_PCLOAD:   state_n = ST_RUN;
            ST_ROLLBACK: state_n = (rb_inc >= RB_MAX) ? ST_FATAL : ST_RUN;
            ST_FATAL:    state_n = ST_FATAL;
            default:     state_n = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state           <= ST_RUN;
            pattern_q       <= 3'b000;
            conf_cnt        <= 16'd0;
            ckpt_pc         <= 32'd0;
            resync_pc       <= 32'd0;
            consec_rb       <= '0;
            stall           <= 1'b0;
            resync_en       <= 1'b0;
            resync_src      <= 2'd0;
            resync_dst      <= 2'd0;
            resync_idx      <= 5'd0;
            pc_load         <= 3'b000;
            pc_load_val     <= 32'd0;
            fault_count_a   <= '0;
            fault_count_b   <= '0;
            fault_count_c   <= '0;
            transient_count <= '0;
            fatal           <= 1'b0;
        end else begin
            state     <= state_n;
            pattern_q <= pattern_n;
            conf_cnt  <= conf_n;

            if (state == ST_RUN && unanimous) begin
                ckpt_pc   <= pc_voted;
                consec_rb <= '0;
            end
            if (state == ST_ROLLBACK) begin
                consec_rb <= rb_inc;
            end
            if (state == ST_CONFIRM && unanimous) begin
                transient_count <= sat_inc(transient_count);
            end

            if (enter_resync) begin
                resync_pc  <= pc_voted;
                resync_src <= src_id;
                resync_dst <= faulty_id;
                case (faulty_id)
                    ID_A:    fault_count_a <= sat_inc(fault_count_a);
                    ID_B:    fault_count_b <= sat_inc(fault_count_b);
                    default: fault_count_c <= sat_inc(fault_count_c);
                endcase
            end

            // outputs are registered from the next state so they line up with it
            stall      <= (state_n != ST_RUN) && (state_n != ST_CONFIRM);
            resync_en  <= (state_n == ST_RESYNC);
            resync_idx <= (state == ST_RESYNC && state_n == ST_RESYNC) ? resync_idx + 5'd1 : 5'd0;
            fatal      <= (state_n == ST_FATAL);
            if (state_n == ST_PCLOAD) begin
                pc_load     <= replica_onehot(resync_dst);
                pc_load_val <= resync_pc;
            end else if (state_n == ST_ROLLBACK) begin
                pc_load     <= 3'b111;
                pc_load_val <= ckpt_pc;
            end else begin
                pc_load <= 3'b000;
            end
        end
    end

endmodule

// File: tb/tb_tmr_recovery_ctrl.sv
// tb/tb_tmr_recovery_ctrl.sv - directed bench with a recovery-plan model for tmr_recovery_ctrl
module tb_tmr_recovery_ctrl;
    import tmr_pkg::*;

    localparam int CONF  = 2;
    localparam int NREGS = 32;
    localparam int RBLIM = 3;
    localparam int CW    = 8;
    localparam int CMAX  = 255;

    logic          clk = 1'b0;
    logic          rst_in = 1'b0;
    logic [2:0]    voter_state = 3'b111;
    logic [31:0]   pc_voted = 32'd0;
    logic          stall, resync_en, fatal;
    logic [1:0]    resync_src, resync_dst;
    logic [4:0]    resync_idx;
    logic [2:0]    pc_load, ctrl_state;
    logic [31:0]   pc_load_val;
    logic [CW-1:0] fault_count_a, fault_count_b, fault_count_c, transient_count;

    int checks = 0;
    int errors = 0;

    tmr_recovery_ctrl #(
        .CONFIRM_CYCLES (CONF),
        .NUM_REGS       (NREGS),
        .ROLLBACK_LIMIT (RBLIM),
        .CNT_W          (CW)
    ) dut (
        .clk             (clk),
        .rst_in          (rst_in),
        .voter_state     (voter_state),
        .pc_voted        (pc_voted),
        .stall           (stall),
        .resync_en       (resync_en),
        .resync_src      (resync_src),
        .resync_dst      (resync_dst),
        .resync_idx      (resync_idx),
        .pc_load         (pc_load),
        .pc_load_val     (pc_load_val),
        .fault_count_a   (fault_count_a),
        .fault_count_b   (fault_count_b),
        .fault_count_c   (fault_count_c),
        .transient_count (transient_count),
        .fatal           (fatal),
        .ctrl_state      (ctrl_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each stalled cycle is a pre-planned slot popped from a queue
    typedef struct packed {
        logic        stall;
        logic        en;
        logic [4:0]  idx;
        logic [1:0]  src;
        logic [1:0]  dst;
        logic [2:0]  load;
        logic [31:0] val;
        logic        fat;
    } slot_t;

    slot_t       plan[$];
    slot_t       e = '0;
    int          m_streak = 0;
    logic [2:0]  m_pat = 3'b000;
    logic [31:0] m_ckpt = 32'd0;
    int          m_rb = 0;
    int          m_fc[3] = '{0, 0, 0};
    int          m_tr = 0;
    bit          m_fatal = 1'b0;

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_reset();
        plan.delete();
        e = '0;
        m_streak = 0;
        m_pat = 3'b000;
        m_ckpt = 32'd0;
        m_rb = 0;
        for (int i = 0; i < 3; i++) m_fc[i] = 0;
        m_tr = 0;
        m_fatal = 1'b0;
    endtask

    task automatic plan_recovery(input logic [2:0] v, input logic [31:0] pc);
        slot_t s;
        int a, b, f;
        if ($countones(v) == 1) begin
            // the single agreeing pair is healthy; the third replica is the culprit
            if (v[2]) begin a = 0; b = 1; end
            else if (v[1]) begin a = 1; b = 2; end
            else begin a = 0; b = 2; end
            f = 3 - a - b;
            m_fc[f] = sat(m_fc[f] + 1);
            for (int k = 0; k < NREGS; k++) begin
                s = '0;
                s.stall = 1'b1; s.en = 1'b1; s.idx = 5'(k);
                s.src = 2'(a); s.dst = 2'(f);
                plan.push_back(s);
            end
            s = '0;
            s.stall = 1'b1; s.load = 3'b100 >> f; s.val = pc;
            plan.push_back(s);
        end else begin
            m_rb++;
            s = '0;
            s.stall = 1'b1; s.load = 3'b111; s.val = m_ckpt;
            plan.push_back(s);
            if (m_rb >= RBLIM) begin
                s = '0;
                s.stall = 1'b1; s.fat = 1'b1;
                plan.push_back(s);
            end
        end
    endtask

    task automatic next_slot();
        if (plan.size() > 0) e = plan.pop_front();
        else e = '0;
        if (e.fat) m_fatal = 1'b1;
    endtask

    task automatic model_step(input logic [2:0] v, input logic [31:0] pc);
        if (m_fatal) begin
            e = '0; e.stall = 1'b1; e.fat = 1'b1;
        end else if (e.stall) begin
            next_slot();
        end else begin
            if (v == 3'b111) begin
                if (m_streak > 0) m_tr = sat(m_tr + 1);
                else begin m_ckpt = pc; m_rb = 0; end
                m_streak = 0;
            end else begin
                if (m_streak > 0 && v == m_pat) m_streak++;
                else begin m_pat = v; m_streak = 1; end
                if (m_streak >= CONF) begin
                    m_streak = 0;
                    plan_recovery(v, pc);
                end
            end
            next_slot();
        end
    endtask

    always @(posedge clk or negedge rst_in) begin
        if (!rst_in) model_reset();
        else model_step(voter_state, pc_voted);
    end

    always @(negedge clk) begin
        if (rst_in) begin
            chk("stall", 32'(stall), 32'(e.stall));
            chk("resync_en", 32'(resync_en), 32'(e.en));
            chk("pc_load", 32'(pc_load), 32'(e.load));
            chk("fatal", 32'(fatal), 32'(e.fat));
            chk("fault_count_a", 32'(fault_count_a), 32'(m_fc[0]));
            chk("fault_count_b", 32'(fault_count_b), 32'(m_fc[1]));
            chk("fault_count_c", 32'(fault_count_c), 32'(m_fc[2]));
            chk("transient_count", 32'(transient_count), 32'(m_tr));
            if (e.en) begin
                chk("resync_idx", 32'(resync_idx), 32'(e.idx));
                chk("resync_src", 32'(resync_src), 32'(e.src));
                chk("resync_dst", 32'(resync_dst), 32'(e.dst));
            end
            if (e.load != 3'b000) chk("pc_load_val", pc_load_val, e.val);
        end
    end

    task automatic drive(input logic [2:0] v, input logic [31:0] pc, input int n);
        voter_state = v;
        pc_voted = pc;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_resync_en"}, 32'(resync_en), 32'd0);
        chk({tag, "_resync_idx"}, 32'(resync_idx), 32'd0);
        chk({tag, "_pc_load"}, 32'(pc_load), 32'd0);
        chk({tag, "_pc_load_val"}, pc_load_val, 32'd0);
        chk({tag, "_fatal"}, 32'(fatal), 32'd0);
        chk({tag, "_fault_counts"}, 32'({fault_count_a, fault_count_b, fault_count_c}), 32'd0);
        chk({tag, "_transient"}, 32'(transient_count), 32'd0);
        chk({tag, "_ctrl_state"}, 32'(ctrl_state), 32'(ST_RUN));
    endtask

    task automatic pulse_reset(input string tag);
        #2 rst_in = 1'b0;
        #1 check_reset_outputs(tag);
        @(negedge clk);
        rst_in = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_in = 1'b1;

        // transient glitch: no stall, counted once
        drive(3'b111, 32'h0, 1);
        drive(3'b111, 32'h4, 1);
        drive(3'b111, 32'h8, 1);
        drive(3'b100, 32'hC, 1);
        drive(3'b111, 32'h10, 3);
        chk("t1_transient", 32'(transient_count), 32'd1);
        chk("t1_stall", 32'(stall), 32'd0);

        // C faulty: copy from A, then reload C at the resync PC
        drive(3'b111, 32'h3C, 1);
        drive(3'b100, 32'h40, 2);
        chk("t2_en", 32'(resync_en), 32'd1);
        chk("t2_src", 32'(resync_src), 32'd0);
        chk("t2_dst", 32'(resync_dst), 32'd2);
        chk("t2_idx0", 32'(resync_idx), 32'd0);
        drive(3'b111, 32'h44, 32);
        chk("t2_pc_load", 32'(pc_load), 32'b001);
        chk("t2_pc_load_val", pc_load_val, 32'h40);
        chk("t2_fault_c", 32'(fault_count_c), 32'd1);
        drive(3'b111, 32'h48, 1);
        chk("t2_run", 32'(stall), 32'd0);

        // A faulty: copy from B
        drive(3'b010, 32'h80, 2);
        chk("t3_src_a", 32'(resync_src), 32'd1);
        chk("t3_dst_a", 32'(resync_dst), 32'd0);
        chk("t3_fault_a", 32'(fault_count_a), 32'd1);
        drive(3'b111, 32'h84, 32);
        chk("t3_pc_load_a", 32'(pc_load), 32'b100);
        drive(3'b111, 32'h88, 1);

        // B faulty: copy from A
        drive(3'b001, 32'h90, 2);
        chk("t3_src_b", 32'(resync_src), 32'd0);
        chk("t3_dst_b", 32'(resync_dst), 32'd1);
        drive(3'b111, 32'h94, 32);
        chk("t3_pc_load_b", 32'(pc_load), 32'b010);
        chk("t3_pc_load_val_b", pc_load_val, 32'h90);
        drive(3'b111, 32'h98, 1);

        // no single culprit: three rollbacks to 0x100 then fatal lock
        drive(3'b111, 32'h100, 1);
        drive(3'b000, 32'h200, 2);
        chk("t4_rb1_load", 32'(pc_load), 32'b111);
        chk("t4_rb1_val", pc_load_val, 32'h100);
        chk("t4_rb1_stall", 32'(stall), 32'd1);
        drive(3'b000, 32'h204, 1);
        chk("t4_rb1_done", 32'(stall), 32'd0);
        drive(3'b000, 32'h208, 2);
        chk("t4_rb2_val", pc_load_val, 32'h100);
        drive(3'b000, 32'h20C, 3);
        chk("t4_rb3_load", 32'(pc_load), 32'b111);
        drive(3'b111, 32'h210, 1);
        chk("t4_fatal", 32'(fatal), 32'd1);
        drive(3'b111, 32'h214, 5);
        chk("t4_fatal_sticky", 32'({fatal, stall}), 32'b11);
        pulse_reset("fatal_reset");

        // confirm restarts when the pattern changes
        drive(3'b111, 32'h300, 1);
        drive(3'b100, 32'h304, 1);
        drive(3'b001, 32'h308, 1);
        chk("t5_restart", 32'(stall), 32'd0);
        drive(3'b001, 32'h30C, 1);
        chk("t5_en", 32'(resync_en), 32'd1);
        chk("t5_dst_b", 32'(resync_dst), 32'd1);
        chk("t5_fault_b", 32'(fault_count_b), 32'd1);

        // asynchronous reset mid-resync
        drive(3'b111, 32'h310, 10);
        chk("t6_idx10", 32'(resync_idx), 32'd10);
        pulse_reset("mid_resync_reset");
        drive(3'b111, 32'h400, 3);
        chk("t6_state", 32'(ctrl_state), 32'(ST_RUN));
        chk("t6_counts", 32'({fault_count_a, fault_count_b, fault_count_c, transient_count}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
